// File: rtl/vga_pkg.sv
// Purpose : shared timing constants, RGB332 pixel type, swap FSM states and the
//           colour-bar helper used by the optional test pattern.
// Ports   : none (package).
package vga_pkg;

  // 640x480@60 timing generator constants (HC/VC coordinates)
  localparam int HBP     = 144;
  localparam int HFP     = 784;
  localparam int VBP     = 31;
  localparam int VFP     = 511;
  localparam int HPIXELS = 800;
  localparam int VLINES  = 521;

  typedef struct packed {
    logic [2:0] r;
    logic [2:0] g;
    logic [1:0] b;
  } rgb332_t;

  typedef enum logic [1:0] {
    IDLE,
    PEND,
    ACKD
  } swap_state_t;

  // Eight full-intensity bars, 40 framebuffer pixels wide each, so that all
  // eight fit across the 320-pixel line. Bar index bits are {R, G, B}.
  function automatic rgb332_t bar_colour(input logic [8:0] x);
    logic [2:0] bar;
    bar = 3'd0;
    for (int i = 1; i < 8; i++) begin
      if (x >= 9'(40 * i)) bar = 3'(i);
    end
    return {{3{bar[2]}}, {3{bar[1]}}, {2{bar[0]}}};
  endfunction

endpackage

// File: rtl/vga_pixel_fetch_if.sv
// Purpose : bundles timing inputs, framebuffer RAM port, swap handshake and DAC
//           pins of vga_pixel_fetch. master = fetch block, slave = surroundings.
// Ports   : PATTERN_SEL exists only when VGA_TEST_PATTERN_EN is defined.
interface vga_pixel_fetch_if #(
  parameter int ADDR_W = 17
);
  logic [9:0]      HC;
  logic [9:0]      VC;
  logic            VIDON;
  logic            HSYNC_IN;
  logic            VSYNC_IN;
  logic [ADDR_W:0] MEM_ADDR;
  logic            MEM_RE;
  logic [7:0]      MEM_DATA;
  logic            SWAP_REQ;
  logic            SWAP_ACK;
  logic            FRONT_BUF;
  logic [2:0]      RED;
  logic [2:0]      GREEN;
  logic [1:0]      BLUE;
  logic            HSYNC;
  logic            VSYNC;
`ifdef VGA_TEST_PATTERN_EN
  logic            PATTERN_SEL;
`endif

  modport master (
    input  HC, VC, VIDON, HSYNC_IN, VSYNC_IN, MEM_DATA, SWAP_REQ,
`ifdef VGA_TEST_PATTERN_EN
    input  PATTERN_SEL,
`endif
    output MEM_ADDR, MEM_RE, SWAP_ACK, FRONT_BUF, RED, GREEN, BLUE, HSYNC, VSYNC
  );

  modport slave (
    output HC, VC, VIDON, HSYNC_IN, VSYNC_IN, MEM_DATA, SWAP_REQ,
`ifdef VGA_TEST_PATTERN_EN
    output PATTERN_SEL,
`endif
    input  MEM_ADDR, MEM_RE, SWAP_ACK, FRONT_BUF, RED, GREEN, BLUE, HSYNC, VSYNC
  );

endinterface

// File: rtl/vga_delay_line.sv
// Purpose : fixed-depth register delay for side-band fields travelling with a
//           RAM read; every stage reloads RESET_VAL on synchronous reset.
// Ports   : clk_i, rst_n_i (sync, active low), din_i, dout_o (din_i delayed DEPTH cycles).
module vga_delay_line #(
  parameter int               WIDTH     = 1,
  parameter int               DEPTH     = 2,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic [WIDTH-1:0] din_i,
  output logic [WIDTH-1:0] dout_o
);

  logic [WIDTH-1:0] stage_q [DEPTH];

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      for (int i = 0; i < DEPTH; i++) stage_q[i] <= RESET_VAL;
    end else begin
      stage_q[0] <= din_i;
      for (int i = 1; i < DEPTH; i++) stage_q[i] <= stage_q[i-1];
    end
  end

  assign dout_o = stage_q[DEPTH-1];

endmodule

// File: rtl/vga_pixel_fetch.sv
// Purpose : turns timing-generator counts into framebuffer reads (320x240 RGB332,
//           2x2 pixel doubling, double buffered) and drives the VGA DAC pins.
// Ports   : CLK, CLR_N (sync, active low), bus (vga_pixel_fetch_if.master).
// Latency : timing inputs to RGB/HSYNC/VSYNC is exactly 3 CLK; no backpressure.
// Swap    : 4-phase SWAP_REQ/SWAP_ACK; FRONT_BUF flips only at VC==VFP, HC==0.
// Config  : VGA_TEST_PATTERN_EN adds bus.PATTERN_SEL selecting 8 colour bars.
module vga_pixel_fetch #(
  parameter int HBP    = vga_pkg::HBP,
  parameter int VBP    = vga_pkg::VBP,
  parameter int VFP    = vga_pkg::VFP,
  parameter int FB_W   = 320,
  parameter int FB_H   = 240,
  parameter int ADDR_W = 17
) (
  input  logic               CLK,
  input  logic               CLR_N,
  vga_pixel_fetch_if.master  bus
);
  import vga_pkg::*;

  if (FB_W * FB_H > (1 << ADDR_W)) begin : g_cfg_check
    $error("framebuffer does not fit in ADDR_W");
  end

  // ---------------- stage 1: address generation ----------------
  logic [9:0]        h_off;
  logic [9:0]        v_off;
  logic [8:0]        x;
  logic [7:0]        y;
  logic [ADDR_W-1:0] pix_idx;
  logic              unused_off_bits;

  assign h_off   = bus.HC - 10'(HBP);
  assign v_off   = bus.VC - 10'(VBP);
  // Halving both offsets maps each framebuffer pixel onto a 2x2 screen block.
  assign x       = h_off[9:1];
  assign y       = v_off[8:1];
  assign pix_idx = ADDR_W'(y) * ADDR_W'(FB_W) + ADDR_W'(x);
  assign unused_off_bits = ^{h_off[0], v_off[0], v_off[9]};

  logic              mem_re_q;
  logic [ADDR_W:0]   mem_addr_q;
  logic              front_buf_q, front_buf_d;

  always_ff @(posedge CLK) begin
    if (!CLR_N) begin
      mem_re_q   <= 1'b0;
      mem_addr_q <= '0;
    end else begin
      mem_re_q <= bus.VIDON;
      // Address is held through blanking so the RAM port stays quiet.
      if (bus.VIDON) mem_addr_q <= {front_buf_q, pix_idx};
    end
  end

  assign bus.MEM_RE   = mem_re_q;
  assign bus.MEM_ADDR = mem_addr_q;

  // ---------------- side band: {vidon, hsync, vsync, x} over 2 stages ----------------
  localparam int PW = 3 + 9;
  // Syncs are active low, so their idle value is 1.
  localparam logic [PW-1:0] PIPE_RST = {1'b0, 1'b1, 1'b1, 9'd0};

  logic [PW-1:0] pipe_d2;
  logic          vidon_d2;
  logic          hsync_d2;
  logic          vsync_d2;
  logic [8:0]    x_d2;

  vga_delay_line #(
    .WIDTH     (PW),
    .DEPTH     (2),
    .RESET_VAL (PIPE_RST)
  ) u_side_dly (
    .clk_i   (CLK),
    .rst_n_i (CLR_N),
    .din_i   ({bus.VIDON, bus.HSYNC_IN, bus.VSYNC_IN, x}),
    .dout_o  (pipe_d2)
  );

  assign {vidon_d2, hsync_d2, vsync_d2, x_d2} = pipe_d2;

  // ---------------- stage 3: pixel output ----------------
  rgb332_t rgb_d, rgb_q;
  logic    hsync_q, vsync_q;

`ifdef VGA_TEST_PATTERN_EN
  always_comb begin
    rgb_d = '0;
    if (vidon_d2) begin
      if (bus.PATTERN_SEL) rgb_d = bar_colour(x_d2);
      else                 rgb_d = rgb332_t'(bus.MEM_DATA);
    end
  end
`else
  logic unused_x_d2;
  assign unused_x_d2 = ^x_d2;

  always_comb begin
    rgb_d = '0;
    if (vidon_d2) rgb_d = rgb332_t'(bus.MEM_DATA);
  end
`endif

  always_ff @(posedge CLK) begin
    if (!CLR_N) begin
      rgb_q   <= '0;
      hsync_q <= 1'b1;
      vsync_q <= 1'b1;
    end else begin
      rgb_q   <= rgb_d;
      hsync_q <= hsync_d2;
      vsync_q <= vsync_d2;
    end
  end

  assign bus.RED   = rgb_q.r;
  assign bus.GREEN = rgb_q.g;
  assign bus.BLUE  = rgb_q.b;
  assign bus.HSYNC = hsync_q;
  assign bus.VSYNC = vsync_q;

  // ---------------- buffer swap FSM ----------------
  swap_state_t state_q, state_d;
  logic        frame_edge;

  // First blanking line, first pixel: the whole visible frame is behind us.
  assign frame_edge = (bus.VC == 10'(VFP)) && (bus.HC == 10'd0);

  always_ff @(posedge CLK) begin
    if (!CLR_N) begin
      state_q     <= IDLE;
      front_buf_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      front_buf_q <= front_buf_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    front_buf_d = front_buf_q;
    case (state_q)
      IDLE: if (bus.SWAP_REQ) state_d = PEND;
      PEND: begin
        // A request withdrawn before the ack cancels the swap.
        if (!bus.SWAP_REQ) begin
          state_d = IDLE;
        end else if (frame_edge) begin
          front_buf_d = ~front_buf_q;
          state_d     = ACKD;
        end
      end
      ACKD: if (!bus.SWAP_REQ) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign bus.SWAP_ACK  = (state_q == ACKD);
  assign bus.FRONT_BUF = front_buf_q;

endmodule
